// File: rtl/cons_pkg.sv
// Shared types for the cons bus scheduler.
//   cons_state_t  : scheduler FSM states
//   result_beat_t : one output beat (coordinates plus LANES result values)
//   sat_burst_len : maps a requested load length onto 1..max_len
package cons_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int LANES      = 3;
    localparam int RES_DATA_W = DATA_WIDTH * LANES;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_TURN,
        S_OUT
    } cons_state_t;

    typedef struct packed {
        logic [31:0]           x;
        logic [31:0]           y;
        logic [31:0]           ch;
        logic [RES_DATA_W-1:0] data;
    } result_beat_t;

    // A zero length still moves one word; anything above max_len is clipped.
    function automatic logic [3:0] sat_burst_len(input logic [3:0] len,
                                                 input logic [3:0] max_len);
        if (len == 4'd0) begin
            return 4'd1;
        end else if (len > max_len) begin
            return max_len;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO of result beats, no fall-through.
//   clk, rst      : clock, synchronous active-high reset (pointers only)
//   push, wr_beat : write request and data; dropped when full unless popping
//   pop, rd_beat  : read request and head-of-queue data
//   count         : fill level, 0..DEPTH
//   full, empty   : status from extra-bit pointer compare
module result_fifo
    import cons_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  result_beat_t           wr_beat,
    output result_beat_t           rd_beat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    result_beat_t   mem_q [DEPTH];
    logic           do_push;
    logic           do_pop;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        count    = wr_ptr_q - rd_ptr_q;
        do_pop   = pop && !empty;
        // At full, a same-cycle pop frees the slot being written.
        do_push  = push && (!full || do_pop);
        wr_ptr_d = do_push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = do_pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        rd_beat  = mem_q[rd_ptr_q[PTR_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_beat;
        end
    end

endmodule

// File: rtl/cons_bus_scheduler.sv
// Time-shares the external cons bus between the load path (host->device)
// and the result drain (device->host), buffering results in a FIFO.
//   clk, rst                 : clock, synchronous active-high reset
//   ld_req, ld_len           : load burst request and length (1..MAX_BURST)
//   ld_gnt, ld_beat          : load owns bus (registered), word accepted
//   res_valid, res_*         : result beat pushed into the FIFO
//   ctrl_stall               : fewer than two free FIFO slots
//   con_valid, con_ready     : load word handshake
//   out_valid, out_ready     : result beat handshake, out_* is FIFO head
//   driving_cons             : device drives the bus (S_OUT only)
//
// state  | meaning
// S_IDLE | bus unowned, picks next owner
// S_LOAD | load burst in progress, never pre-empted
// S_TURN | one dead cycle while bus direction flips
// S_OUT  | device drains FIFO onto the bus
module cons_bus_scheduler
    import cons_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int HIGH_WATER = 6,
    parameter int MAX_BURST  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_req,
    input  logic [3:0]            ld_len,
    output logic                  ld_gnt,
    output logic                  ld_beat,
    input  logic                  res_valid,
    input  logic [31:0]           res_x,
    input  logic [31:0]           res_y,
    input  logic [31:0]           res_ch,
    input  logic [RES_DATA_W-1:0] res_data,
    output logic                  ctrl_stall,
    input  logic                  con_valid,
    output logic                  con_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_x,
    output logic [31:0]           out_y,
    output logic [31:0]           out_ch,
    output logic [RES_DATA_W-1:0] out_data,
    output logic                  driving_cons
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] HW_LVL    = CNT_W'(HIGH_WATER);
    localparam logic [CNT_W-1:0] STALL_LVL = CNT_W'(FIFO_DEPTH - 2);
    localparam logic [3:0]       MAX_LEN   = 4'(MAX_BURST);

    cons_state_t  state_q, state_d;
    cons_state_t  turn_to_q, turn_to_d;
    logic [3:0]   burst_q, burst_d;
    logic         ld_gnt_q, ld_gnt_d;

    result_beat_t wr_beat;
    result_beat_t head;
    logic [CNT_W-1:0] fifo_count;
    logic         fifo_full;
    logic         fifo_empty;
    logic         out_high;
    logic         fifo_pop;

    assign wr_beat = '{x: res_x, y: res_y, ch: res_ch, data: res_data};

    result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (res_valid),
        .pop     (fifo_pop),
        .wr_beat (wr_beat),
        .rd_beat (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // fifo_full keeps the priority rule sane if HIGH_WATER is set above depth.
    assign out_high     = fifo_full || (fifo_count >= HW_LVL);
    assign ctrl_stall   = (fifo_count > STALL_LVL);
    assign ld_gnt       = ld_gnt_q;
    assign con_ready    = ld_gnt_q;
    assign ld_beat      = ld_gnt_q && con_valid;
    assign driving_cons = (state_q == S_OUT);
    assign out_valid    = driving_cons && !fifo_empty;
    assign fifo_pop     = out_valid && out_ready;

    // Data lines read 0 whenever no beat is offered.
    assign out_x    = out_valid ? head.x    : '0;
    assign out_y    = out_valid ? head.y    : '0;
    assign out_ch   = out_valid ? head.ch   : '0;
    assign out_data = out_valid ? head.data : '0;

    always_comb begin
        state_d   = state_q;
        turn_to_d = turn_to_q;
        burst_d   = burst_q;
        case (state_q)
            S_IDLE: begin
                if (out_high) begin
                    state_d   = S_TURN;
                    turn_to_d = S_OUT;
                end else if (ld_req) begin
                    state_d = S_LOAD;
                    burst_d = sat_burst_len(ld_len, MAX_LEN);
                end else if (!fifo_empty) begin
                    state_d   = S_TURN;
                    turn_to_d = S_OUT;
                end
            end
            S_LOAD: begin
                if (ld_beat) begin
                    burst_d = burst_q - 4'd1;
                    if (burst_q == 4'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_TURN: begin
                state_d = turn_to_q;
            end
            S_OUT: begin
                // A pending load may only take over once the offered beat has
                // been accepted; an offered beat is never withdrawn.
                if (fifo_empty || (ld_req && !out_high && out_ready)) begin
                    state_d   = S_TURN;
                    turn_to_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        ld_gnt_d = (state_d == S_LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            turn_to_q <= S_IDLE;
            burst_q   <= 4'd0;
            ld_gnt_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            turn_to_q <= turn_to_d;
            burst_q   <= burst_d;
            ld_gnt_q  <= ld_gnt_d;
        end
    end

endmodule
